// File: rtl/gray_counter.sv
// ----------------------------------------------------------------------------
// gray_counter
//
// Parametrised synchronous up/down counter. The count is held in binary and
// also presented as Gray code. Both forms come from registers and update on
// the same clock edge. In clock-domain-crossing paths only the Gray output
// should cross domains; one Gray bit changes per count step.
//
// Parameters
//   WIDTH     : counter and code width in bits (>= 2)
//   WRAP      : 1 = wrap modulo 2^WIDTH, 0 = saturate at the end values
//   RESET_VAL : binary count loaded while rst_n is low
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   en           in   count enable (one step per cycle)
//   up           in   direction: 1 = increment, 0 = decrement
//   load         in   synchronous parallel load (has priority over en)
//   load_is_gray in   1 = load_val is Gray coded, 0 = binary
//   load_val     in   parallel load value
//   bin          out  registered binary count
//   gray         out  registered Gray code of bin
//   tc           out  terminal count for the current direction
//                     (combinational from the registered count and up)
//   wrapped      out  registered one-cycle pulse after a wrap-around edge
// ----------------------------------------------------------------------------
module gray_counter #(
    parameter int               WIDTH     = 4,
    parameter bit               WRAP      = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_is_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrapped_q, wrapped_d;
    logic [WIDTH-1:0] load_bin;
    logic             at_end;

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: prefix XOR running from the MSB down to bit 0.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign load_bin = load_is_gray ? gray2bin(load_val) : load_val;

    // End of the range in the current counting direction; doubles as tc.
    assign at_end = up ? (bin_q == ALL_ONES) : (bin_q == '0);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the if/else chain can infer a latch.
        bin_d     = bin_q;
        wrapped_d = 1'b0;

        if (load) begin
            bin_d = load_bin;
        end else if (en) begin
            if (at_end && !WRAP) begin
                bin_d = bin_q;                      // saturate: hold the end value
            end else begin
                bin_d     = up ? (bin_q + ONE) : (bin_q - ONE);
                wrapped_d = at_end;
            end
        end

        // Gray is derived from the next binary value so both registers
        // always load a mutually consistent pair on the same edge.
        gray_d = bin2gray(bin_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q     <= RESET_VAL;
            gray_q    <= bin2gray(RESET_VAL);
            wrapped_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling
            // the pre-edge values, independent of statement order.
            bin_q     <= bin_d;
            gray_q    <= gray_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign bin     = bin_q;
    assign gray    = gray_q;
    assign wrapped = wrapped_q;
    assign tc      = at_end;

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Parametrised synchronous up/down counter that holds a binary count and presents it in both binary and Gray code, with registered outputs.
- Successor to the team's fixed 4-bit combinational binary-to-Gray converter: adds generic width, bidirectional counting, parallel load in binary or Gray form, and wrap/saturate mode.
- Used as a pointer and sequence generator in clock-domain-crossing paths. Only the Gray output crosses domains.

Parameters:
- WIDTH, 4, counter and code width in bits (≥2).
- WRAP, 1, 1 = modulo-2^WIDTH wrap-around; 0 = saturate at the end values.
- RESET_VAL, 0, binary count value loaded on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; steps the count one position per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load strobe.
- load_is_gray  input  1  1 = load_val is Gray-coded; 0 = load_val is binary.
- load_val  input  WIDTH  parallel load value.
- bin  output  WIDTH  registered binary count.
- gray  output  WIDTH  registered Gray code of bin: gray = bin ^ (bin >> 1).
- tc  output  1  terminal count (combinational from registered state): bin == all-ones when up = 1; bin == 0 when up = 0.
- wrapped  output  1  registered one-cycle pulse marking a wrap-around.

Behaviour:
- Reset: rst_n low forces the following immediately, independent of clk, and holds them while low:
  - bin = RESET_VAL
  - gray = RESET_VAL ^ (RESET_VAL >> 1)
  - wrapped = 0
- First update after reset is on the first rising edge with rst_n high.
- Reset mid-count discards the count in progress; no partial update.
- Output registering: bin and gray are both registered.
  - gray is computed from the next binary value, not the current one.
  - bin and gray therefore change on the same edge and are always mutually consistent.
  - Only one gray bit toggles per count step. A load may toggle several.
- Priority per rising edge: load > en > hold.
- Load:
  - load_is_gray = 0: next bin = load_val.
  - load_is_gray = 1: next bin[WIDTH-1] = load_val[WIDTH-1]; next bin[i] = bin_next[i+1] ^ load_val[i], i.e. a prefix XOR from the MSB down. This is single-cycle combinational.
  - wrapped = 0 on the load cycle.
  - en is ignored on the load cycle.
- Count, en = 1 and load = 0:
  - up = 1: next bin = bin + 1.
  - up = 0: next bin = bin − 1.
  - Width rule: the sum is WIDTH bits, with the carry/borrow discarded.
- Boundary at all-ones with up = 1, or at 0 with up = 0:
  - WRAP = 1: bin wraps to 0 or to all-ones respectively; wrapped = 1 for exactly the cycle following the wrap edge.
  - WRAP = 0: bin and gray hold their value; wrapped stays 0.
- Hold: en = 0 and load = 0 leaves bin and gray unchanged and sets wrapped = 0.
- Direction change: up may change on any cycle.
  - tc follows up combinationally.
  - No state depends on the previous direction.
- No internal state machine beyond the count register. wrapped is the only sequential flag.

Test Plan:
- Reset, WIDTH=4: assert rst_n=0 mid-count at bin=6 → bin=0, gray=0, wrapped=0 immediately (before the next clk edge). After release with en=0, values hold.
- Up-count, WIDTH=4, WRAP=1: en=1, up=1 for 17 cycles from 0 → gray sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0. tc=1 while bin=F. wrapped=1 only in the cycle bin returns to 0. A checker confirms a single gray bit toggles per step.
- Down wrap: from bin=0, en=1, up=0 → bin=F, gray=8, wrapped=1 for one cycle. Next cycle: bin=E, gray=9, wrapped=0.
- Gray load: load=1, load_is_gray=1, load_val=4'b1000 → bin=F, gray=8. Load of load_val=4'b0110 → bin=4, gray=6. Binary load of 4'b1010 → bin=A, gray=F.
- Load versus enable: load=1, en=1, up=1, load_val=3 (binary) in the same cycle → bin=3 (not 4), wrapped=0.
- Saturate, WRAP=0, WIDTH=8: count to FF, hold en=1, up=1 for 3 more cycles → bin=FF, gray=80, wrapped never asserts. Then up=0 → FE on the next edge.
